// File: rtl/timer_peripheral.sv
// timer_peripheral
//   Memory-mapped auto-reload interval timer for the peripheral bus.
//   Register map (byte addresses):
//     BASE_ADDR+0  TH   reload value
//     BASE_ADDR+4  TL   up-counter
//     BASE_ADDR+8  TCON [0] EN, [1] IE, [2] ST (sticky, clear-only from SW),
//                       [3] OS (one-shot, only when TIMER_ONESHOT_EN is defined)
//   Optional feature macro: TIMER_ONESHOT_EN
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous active-low reset
//     Address    byte address from the CPU
//     Write_data store data
//     MemRead    load strobe (combinational read path)
//     MemWrite   store strobe, sampled on rising clk
//     Read_data  selected register, 0 when not selected (OR-merged bus)
//     irq        level interrupt = IE & ST
//   BASE_ADDR is expected to be word aligned, so the full 32-bit compare
//   also enforces Address[1:0] == 0.
module timer_peripheral #(
   parameter logic [31:0] BASE_ADDR = 32'h40000000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] Read_data,
   output logic        irq
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [31:0] th, tl;
   logic        en, ie, st;
   logic [15:0] ps_cnt;
   logic        os;

   logic hit_th, hit_tl, hit_tcon;
   logic we_th, we_tl, we_tcon;
   logic tick, ovf;
   logic [31:0] tcon_val;

   assign hit_th   = (Address == BASE_ADDR);
   assign hit_tl   = (Address == BASE_ADDR + 32'd4);
   assign hit_tcon = (Address == BASE_ADDR + 32'd8);

   assign we_th   = MemWrite & hit_th;
   assign we_tl   = MemWrite & hit_tl;
   assign we_tcon = MemWrite & hit_tcon;

   // Tick and overflow are judged on the current register state, so a
   // same-cycle write to TCON/TH only affects later edges.
   assign tick = en & (ps_cnt == PS_LAST);
   assign ovf  = tick & (tl == 32'hFFFF_FFFF);

   assign tcon_val = {28'b0, os, st, ie, en};
   assign irq      = ie & st;

`ifndef TIMER_ONESHOT_EN
   assign os = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th     <= '0;
         tl     <= '0;
         en     <= 1'b0;
         ie     <= 1'b0;
         st     <= 1'b0;
         ps_cnt <= '0;
`ifdef TIMER_ONESHOT_EN
         os     <= 1'b0;
`endif
      end else begin
         if (!en || tick) ps_cnt <= '0;
         else             ps_cnt <= ps_cnt + 16'd1;

         if (we_th) th <= Write_data;

         // CPU write beats the count/reload; the reload reads the old TH.
         if (we_tl)     tl <= Write_data;
         else if (tick) tl <= ovf ? th : tl + 32'd1;

         if (we_tcon) begin
            en <= Write_data[0];
            ie <= Write_data[1];
         end

         // Software may only clear ST; a hardware set in the same cycle wins.
         st <= (we_tcon ? (st & Write_data[2]) : st) | (ovf & ie);

`ifdef TIMER_ONESHOT_EN
         if (we_tcon) os <= Write_data[3];
         // Overrides any EN written by software in this same cycle.
         if (ovf && os) en <= 1'b0;
`endif
      end
   end

   always_comb begin
      Read_data = '0;
      if (MemRead) begin
         if (hit_th)   Read_data = th;
         if (hit_tl)   Read_data = tl;
         if (hit_tcon) Read_data = tcon_val;
      end
   end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral. Instance u_dut0 uses PRESCALE=1 at
// the default base; u_dut1 uses PRESCALE=4 at a separate base so both share
// the bus without address overlap.
module tb_timer_peripheral;

   localparam logic [31:0] A_TH  = 32'h40000000;
   localparam logic [31:0] A_TL  = 32'h40000004;
   localparam logic [31:0] A_TC  = 32'h40000008;
   localparam logic [31:0] B1    = 32'h40001000;
   localparam logic [31:0] B1_TL = 32'h40001004;
   localparam logic [31:0] B1_TC = 32'h40001008;

   logic        clk, reset;
   logic [31:0] Address, Write_data;
   logic        MemRead, MemWrite;
   logic [31:0] rd0, rd1;
   logic        irq0, irq1;

   int n_cmp, n_bad;

   timer_peripheral #(.BASE_ADDR(A_TH), .PRESCALE(1)) u_dut0 (
      .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rd0), .irq(irq0));

   timer_peripheral #(.BASE_ADDR(B1), .PRESCALE(4)) u_dut1 (
      .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rd1), .irq(irq1));

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[29];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Combinational read within the current low clock phase; no edge consumed.
   task automatic peek(input logic [31:0] a, input logic [31:0] e, input int which,
                       input string name);
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      Address  = a;
      #1;
      check(name, (which == 1) ? rd1 : rd0, e);
      MemRead = 1'b0;
   endtask

   // Drive a store at the falling edge; it commits at the following rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemRead    = 1'b0;
      MemWrite   = 1'b1;
      Address    = a;
      Write_data = d;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;

      // Each row: drive at falling edge, check, then one rising edge elapses.
      tbl[0]  = '{1'b1, 1'b0, A_TH, 32'hFFFFFFFC, 32'h0,        1'b0};
      tbl[1]  = '{1'b1, 1'b0, A_TL, 32'hFFFFFFFC, 32'h0,        1'b0};
      tbl[2]  = '{1'b1, 1'b0, A_TC, 32'h3,        32'h0,        1'b0};
      tbl[3]  = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFC, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFD, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFE, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFF, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFC, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, A_TC, 32'h3,        32'h7,        1'b1};
      tbl[9]  = '{1'b0, 1'b1, A_TC, 32'h0,        32'h3,        1'b0};
      tbl[10] = '{1'b1, 1'b1, A_TC, 32'h3,        32'h3,        1'b0};
      tbl[11] = '{1'b0, 1'b1, A_TC, 32'h0,        32'h7,        1'b1};
      tbl[12] = '{1'b1, 1'b1, A_TC, 32'h3,        32'h7,        1'b1};
      tbl[13] = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFE, 1'b0};
      tbl[14] = '{1'b1, 1'b1, A_TH, 32'h100,      32'hFFFFFFFC, 1'b0};
      tbl[15] = '{1'b0, 1'b1, A_TL, 32'h0,        32'hFFFFFFFC, 1'b1};
      tbl[16] = '{1'b0, 1'b1, A_TH, 32'h0,        32'h100,      1'b1};
      tbl[17] = '{1'b1, 1'b1, A_TL, 32'h55,       32'hFFFFFFFE, 1'b1};
      tbl[18] = '{1'b0, 1'b1, A_TL, 32'h0,        32'h55,       1'b1};
      tbl[19] = '{1'b1, 1'b1, A_TC, 32'h0,        32'h7,        1'b1};
      tbl[20] = '{1'b0, 1'b1, A_TL, 32'h0,        32'h57,       1'b0};
      tbl[21] = '{1'b0, 1'b1, A_TL, 32'h0,        32'h57,       1'b0};
      tbl[22] = '{1'b0, 1'b1, A_TH + 32'd12, 32'h0, 32'h0,      1'b0};
      tbl[23] = '{1'b0, 1'b0, A_TC, 32'h0,        32'h0,        1'b0};
      tbl[24] = '{1'b1, 1'b0, A_TH + 32'd16, 32'hFFFFFFFF, 32'h0, 1'b0};
      tbl[25] = '{1'b0, 1'b1, A_TH, 32'h0,        32'h100,      1'b0};
      tbl[26] = '{1'b0, 1'b1, A_TL, 32'h0,        32'h57,       1'b0};
      tbl[27] = '{1'b0, 1'b1, A_TC, 32'h0,        32'h0,        1'b0};
      tbl[28] = '{1'b0, 1'b1, A_TH + 32'd1, 32'h0, 32'h0,       1'b0};

      // Reset state
      #5;
      peek(A_TH, 32'h0, 0, "rst_th");
      peek(A_TL, 32'h0, 0, "rst_tl");
      peek(A_TC, 32'h0, 0, "rst_tcon");
      check("rst_irq", {31'b0, irq0}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Periodic reload, status-clear race, TH/TL write races, decode
      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         MemWrite   = tbl[i].we;
         MemRead    = tbl[i].re;
         Address    = tbl[i].addr;
         Write_data = tbl[i].wdata;
         #1;
         check($sformatf("vec%0d_rd", i), rd0, tbl[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'b0, irq0}, {31'b0, tbl[i].exp_irq});
      end
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      MemRead  = 1'b0;

      // Prescale = 4 on the second instance
      wr(B1_TC, 32'h1);
      repeat (11) @(posedge clk);
      @(negedge clk);
      peek(B1_TL, 32'h2, 1, "ps_tl_11");
      @(posedge clk);
      @(negedge clk);
      peek(B1_TL, 32'h3, 1, "ps_tl_12");
      wr(B1_TC, 32'h0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      peek(B1_TL, 32'h3, 1, "ps_tl_frozen");

      // TL write in the same cycle as an overflow: write wins, ST still set
      wr(A_TL, 32'hFFFFFFFE);
      wr(A_TC, 32'h3);
      @(posedge clk);
      wr(A_TL, 32'h10);
      @(negedge clk);
      peek(A_TL, 32'h10, 0, "ovf_wr_tl");
      peek(A_TC, 32'h7, 0, "ovf_wr_tcon");
      check("ovf_wr_irq", {31'b0, irq0}, 32'h1);
      wr(A_TC, 32'h0);

      // One-shot stimulus
      wr(A_TH, 32'h5);
      wr(A_TL, 32'hFFFFFFFE);
      wr(A_TC, 32'hB);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      peek(A_TL, 32'h5, 0, "os_tl");
`ifdef TIMER_ONESHOT_EN
      peek(A_TC, 32'hE, 0, "os_tcon");
`else
      peek(A_TC, 32'h7, 0, "os_tcon");
`endif
      check("os_irq", {31'b0, irq0}, 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
`ifdef TIMER_ONESHOT_EN
      peek(A_TL, 32'h5, 0, "os_tl_hold");
`else
      peek(A_TL, 32'h8, 0, "os_tl_hold");
`endif

      // Asynchronous reset mid-count
      wr(A_TL, 32'h10);
      wr(A_TC, 32'h3);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_rd_idle", rd0, 32'h0);
      check("midrst_irq", {31'b0, irq0}, 32'h0);
      peek(A_TH, 32'h0, 0, "midrst_th");
      peek(A_TL, 32'h0, 0, "midrst_tl");
      peek(A_TC, 32'h0, 0, "midrst_tcon");
      peek(B1_TL, 32'h0, 1, "midrst_tl1");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
